// File: rtl/prog_rom_loader.sv
// Program ROM loader: receives a program as a byte stream into a DEPTH x 8 memory,
// optionally verifies a trailing checksum, then serves instructions to the core and gates its run.
module prog_rom_loader #(
    parameter int ADDR_W   = 4,
    parameter int CHECKSUM = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        opecode,
    output logic [3:0]        imm,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [7:0]        sum;
    logic [7:0]        sum_next;
    logic              accept;
    logic              last_byte;
    logic              sum_ok;
    logic              start_load;

    assign accept    = in_valid && in_ready;
    assign last_byte = (wr_ptr == ADDR_W'(DEPTH - 1));
    assign sum_next  = sum + in_data;
    assign sum_ok    = (sum_next == 8'h00);

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        start_load = 1'b0;
        case (state)
            IDLE: begin
                if (load_req) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (accept && last_byte) begin
                    if (CHECKSUM != 0) begin
                        next_state = CHECK;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            CHECK: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (sum_ok) begin
                        next_state = RUN;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RUN: begin
                if (load_req) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // cpu_run and load_done look at next_state so they are valid in the first RUN cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= next_state;
            cpu_run   <= (next_state == RUN);
            load_done <= (next_state == RUN) && (state != RUN);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr   <= '0;
            sum      <= 8'h00;
            load_err <= 1'b0;
        end else begin
            if (start_load) begin
                wr_ptr   <= '0;
                sum      <= 8'h00;
                load_err <= 1'b0;
            end else if (state == LOAD && accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                sum    <= sum_next;
            end else if (state == CHECK && accept && !sum_ok) begin
                load_err <= 1'b1;
            end
        end
    end

    // Reset wipes the whole program so a half-loaded image can never run.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (state == LOAD && accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        opecode = 4'h0;
        imm     = 4'h0;
        if (state == RUN) begin
            opecode = mem[addr][7:4];
            imm     = mem[addr][3:0];
        end
    end

endmodule

// File: tb/tb_prog_rom_loader.sv
// Bench for prog_rom_loader: one instance with checksum, one without; read-back through a
// scoreboard queue driven from address tables, plus sequences for load/reload/reset corners.
module tb_prog_rom_loader;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_entry_t;

    logic       clk;
    logic       n_rst;
    logic       load_req, in_valid, in_ready, cpu_run, load_done, load_err;
    logic [7:0] in_data;
    logic [3:0] addr, opecode, imm;
    logic       load_req_z, in_valid_z, in_ready_z, cpu_run_z, load_done_z, load_err_z;
    logic [7:0] in_data_z;
    logic [3:0] addr_z, opecode_z, imm_z;

    int        errors = 0;
    int        checks = 0;
    int        acc_cnt = 0;
    int        acc_cnt_z = 0;
    int        acc_start;
    sb_entry_t sb_q[$];
    rd_vec_t   good_tbl[16], zero_tbl[16], nine_tbl[16], a5_tbl[16];

    prog_rom_loader #(.ADDR_W(4), .CHECKSUM(1)) dut (
        .clk(clk), .n_rst(n_rst), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .addr(addr), .opecode(opecode),
        .imm(imm), .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err)
    );

    prog_rom_loader #(.ADDR_W(4), .CHECKSUM(0)) dut_z (
        .clk(clk), .n_rst(n_rst), .load_req(load_req_z), .in_valid(in_valid_z),
        .in_data(in_data_z), .in_ready(in_ready_z), .addr(addr_z), .opecode(opecode_z),
        .imm(imm_z), .cpu_run(cpu_run_z), .load_done(load_done_z), .load_err(load_err_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (in_valid && in_ready) acc_cnt++;
        if (in_valid_z && in_ready_z) acc_cnt_z++;
    end

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [7:0] exp, input bit use_z,
                                 input string name);
        sb_entry_t e;
        if (use_z) addr_z = a;
        else       addr = a;
        e.name = $sformatf("%s[addr=%0d]", name, a);
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input bit use_z);
        sb_entry_t  e;
        logic [7:0] act;
        #1;
        act = use_z ? {opecode_z, imm_z} : {opecode, imm};
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: empty queue, got 0x%02h", act);
        end else begin
            e = sb_q.pop_front();
            check_val(e.name, act, e.exp);
        end
    endtask

    task automatic run_table(input rd_vec_t tbl[16], input bit use_z, input string name);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(tbl[i].addr, tbl[i].exp, use_z, name);
            checkOutput(use_z);
        end
    endtask

    task automatic start_load(input bit use_z);
        if (use_z) load_req_z = 1'b1;
        else       load_req = 1'b1;
        @(negedge clk);
        load_req   = 1'b0;
        load_req_z = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stalls, input bit use_z);
        for (int s = 0; s < stalls; s++) begin
            in_valid = 1'b0;
            check_val("in_ready_stall", {7'd0, in_ready}, 8'd1);
            @(negedge clk);
        end
        if (use_z) begin
            check_val("in_ready_z_load", {7'd0, in_ready_z}, 8'd1);
            in_valid_z = 1'b1;
            in_data_z  = b;
        end else begin
            check_val("in_ready_load", {7'd0, in_ready}, 8'd1);
            in_valid = 1'b1;
            in_data  = b;
        end
        @(negedge clk);
        in_valid   = 1'b0;
        in_valid_z = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0;
        load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; addr = 4'h0;
        load_req_z = 1'b0; in_valid_z = 1'b0; in_data_z = 8'h00; addr_z = 4'h0;

        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            a = 4'((i * 7) % 16);
            good_tbl[i].addr = a; good_tbl[i].exp = 8'(a) + 8'd1;
            zero_tbl[i].addr = a; zero_tbl[i].exp = 8'h00;
            nine_tbl[i].addr = a; nine_tbl[i].exp = 8'h90;
            a5_tbl[i].addr   = a; a5_tbl[i].exp   = 8'hA5;
        end

        repeat (2) @(negedge clk);
        check_val("rst_in_ready", {7'd0, in_ready}, 8'd0);
        check_val("rst_cpu_run", {7'd0, cpu_run}, 8'd0);
        check_val("rst_load_done", {7'd0, load_done}, 8'd0);
        check_val("rst_load_err", {7'd0, load_err}, 8'd0);
        check_val("rst_instr", {opecode, imm}, 8'h00);
        n_rst = 1'b1;
        @(negedge clk);

        $display("[TB] good load");
        start_load(1'b0);
        check_val("good_enter_in_ready", {7'd0, in_ready}, 8'd1);
        for (int b = 1; b <= 16; b++) send_byte(8'(b), 0, 1'b0);
        send_byte(8'h78, 0, 1'b0);
        check_val("good_cpu_run", {7'd0, cpu_run}, 8'd1);
        check_val("good_load_done", {7'd0, load_done}, 8'd1);
        check_val("good_in_ready_run", {7'd0, in_ready}, 8'd0);
        check_val("good_load_err", {7'd0, load_err}, 8'd0);
        @(negedge clk);
        check_val("good_load_done_pulse", {7'd0, load_done}, 8'd0);
        check_val("good_cpu_run_hold", {7'd0, cpu_run}, 8'd1);
        run_table(good_tbl, 1'b0, "good_read");

        $display("[TB] bad checksum");
        start_load(1'b0);
        check_val("bad_cpu_run_drop", {7'd0, cpu_run}, 8'd0);
        for (int b = 1; b <= 16; b++) send_byte(8'(b), 0, 1'b0);
        send_byte(8'h77, 0, 1'b0);
        check_val("bad_load_err", {7'd0, load_err}, 8'd1);
        check_val("bad_cpu_run", {7'd0, cpu_run}, 8'd0);
        check_val("bad_load_done", {7'd0, load_done}, 8'd0);
        check_val("bad_in_ready_idle", {7'd0, in_ready}, 8'd0);
        @(negedge clk);
        check_val("bad_load_err_sticky", {7'd0, load_err}, 8'd1);
        run_table(zero_tbl, 1'b0, "bad_read");

        $display("[TB] backpressure");
        acc_start = acc_cnt;
        start_load(1'b0);
        check_val("bp_load_err_cleared", {7'd0, load_err}, 8'd0);
        for (int b = 1; b <= 17; b++) begin
            send_byte((b == 17) ? 8'h78 : 8'(b), (b % 2 == 0) ? 2 : 0, 1'b0);
        end
        check_val("bp_cpu_run", {7'd0, cpu_run}, 8'd1);
        check_val("bp_load_done", {7'd0, load_done}, 8'd1);
        check_val("bp_accepted", 8'(acc_cnt - acc_start), 8'd17);
        run_table(good_tbl, 1'b0, "bp_read");

        $display("[TB] reload from run");
        start_load(1'b0);
        check_val("reload_cpu_run", {7'd0, cpu_run}, 8'd0);
        check_val("reload_load_err", {7'd0, load_err}, 8'd0);
        check_val("reload_in_ready", {7'd0, in_ready}, 8'd1);
        check_val("reload_instr_off", {opecode, imm}, 8'h00);
        for (int b = 0; b < 16; b++) send_byte(8'h90, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        check_val("reload_run", {7'd0, cpu_run}, 8'd1);
        check_val("reload_done", {7'd0, load_done}, 8'd1);
        run_table(nine_tbl, 1'b0, "reload_read");

        $display("[TB] reset mid-load");
        start_load(1'b0);
        for (int b = 0; b < 5; b++) send_byte(8'h3C, 0, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        check_val("midrst_in_ready", {7'd0, in_ready}, 8'd0);
        check_val("midrst_cpu_run", {7'd0, cpu_run}, 8'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 16; i++) check_val($sformatf("midrst_mem[%0d]", i), dut.mem[i], 8'h00);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("midrst_idle_in_ready", {7'd0, in_ready}, 8'd0);
            check_val("midrst_idle_cpu_run", {7'd0, cpu_run}, 8'd0);
        end
        in_valid = 1'b0;
        run_table(zero_tbl, 1'b0, "midrst_read");

        $display("[TB] no-checksum instance");
        start_load(1'b1);
        for (int b = 0; b < 16; b++) send_byte(8'hA5, 0, 1'b1);
        check_val("z_cpu_run", {7'd0, cpu_run_z}, 8'd1);
        check_val("z_load_done", {7'd0, load_done_z}, 8'd1);
        check_val("z_in_ready_run", {7'd0, in_ready_z}, 8'd0);
        in_valid_z = 1'b1;
        in_data_z  = 8'h11;
        @(negedge clk);
        check_val("z_load_done_pulse", {7'd0, load_done_z}, 8'd0);
        repeat (2) @(negedge clk);
        in_valid_z = 1'b0;
        check_val("z_accepted", 8'(acc_cnt_z), 8'd16);
        check_val("z_load_err", {7'd0, load_err_z}, 8'd0);
        run_table(a5_tbl, 1'b1, "z_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
